icache_responder: RTL and testbench

Direct-mapped instruction cache that serves the fetch side of the CPU.
- Fetch side: receives the PC fetch strobe and address; returns one instruction with a single-cycle valid pulse.
- Hits are answered from on-chip tag/data arrays.
- Misses are refilled one word at a time from a backing instruction memory over a req/ack/valid handshake.

---
 rtl/icache_responder.sv | 157 +++++++++++++++
 tb/tb_icache_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer one edge after
// the fetch strobe; misses refill a single word over a req/ack/valid handshake.
module icache_responder #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_ce,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              inst_enable,
    output logic [INST_W-1:0] inst,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_valid,
    input  logic [INST_W-1:0] mem_data
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        MEM_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [INST_W-1:0]   data_mem [LINES];

    logic [ADDR_W-3:0]   req_word_q, req_word_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                inst_enable_q, inst_enable_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [INDEX_W-1:0]  fetch_index;
    logic [TAG_W-1:0]    fetch_tag;
    logic [INDEX_W-1:0]  fill_index;
    logic [TAG_W-1:0]    fill_tag;
    logic                hit;
    logic                fill_done;
    logic                install;
    logic                unused_addr_bits;

    // Byte offset within the word carries no information for a word cache.
    assign unused_addr_bits = ^pc_addr[1:0];

    assign fetch_index = pc_addr[INDEX_W+1:2];
    assign fetch_tag   = pc_addr[ADDR_W-1:INDEX_W+2];
    assign fill_index  = req_word_q[INDEX_W-1:0];
    assign fill_tag    = req_word_q[ADDR_W-3:INDEX_W];
    assign hit         = valid_q[fetch_index] && (tag_mem[fetch_index] == fetch_tag);

    // Flush on the completing edge wins: the word is delivered but not kept.
    assign install = fill_done && !flush;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d       = state_q;
        req_word_d    = req_word_q;
        inst_d        = inst_q;
        inst_enable_d = 1'b0;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        fill_done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!flush && pc_ce) begin
                    if (hit) begin
                        inst_d        = data_mem[fetch_index];
                        inst_enable_d = 1'b1;
                    end else begin
                        req_word_d = pc_addr[ADDR_W-1:2];
                        mem_req_d  = 1'b1;
                        mem_addr_d = {pc_addr[ADDR_W-1:2], 2'b00};
                        state_d    = MEM_REQ;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_ack) begin
                    if (mem_valid) begin
                        fill_done = 1'b1;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_valid) begin
                    fill_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fill_done) begin
            inst_d        = mem_data;
            inst_enable_d = 1'b1;
            mem_req_d     = 1'b0;
            state_d       = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            req_word_q    <= '0;
            inst_q        <= '0;
            inst_enable_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_word_q    <= req_word_d;
            inst_q        <= inst_d;
            inst_enable_q <= inst_enable_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (install) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are not reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mem_data;
        end
    end

    assign inst        = inst_q;
    assign inst_enable = inst_enable_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: fixed-latency step checks plus a queue
// scoreboard that pairs every inst_enable pulse with an expected instruction.
module tb_icache_responder;

    logic        clk;
    logic        rst;
    logic        pc_ce;
    logic [31:0] pc_addr;
    logic        inst_enable;
    logic [31:0] inst;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_valid;
    logic [31:0] mem_data;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];

    icache_responder #(.ADDR_W(32), .INST_W(32), .INDEX_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_ce      (pc_ce),
        .pc_addr    (pc_addr),
        .inst_enable(inst_enable),
        .inst       (inst),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Scoreboard: each response pulse must match the oldest expected instruction.
    always @(negedge clk) begin
        if (rst && inst_enable) begin
            if (exp_q.size() == 0)
                check("spurious_enable", 32'(inst_enable), 32'd0);
            else
                check("sb_inst", inst, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_miss(input string tag, input logic [31:0] addr);
        pc_ce   = 1'b1;
        pc_addr = addr;
        tick();
        pc_ce = 1'b0;
        check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        check({tag, "_mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_no_enable"}, 32'(inst_enable), 32'd0);
    endtask

    task automatic fill_same_cycle(input string tag, input logic [31:0] data);
        mem_ack   = 1'b1;
        mem_valid = 1'b1;
        mem_data  = data;
        exp_q.push_back(data);
        tick();
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        check({tag, "_enable"}, 32'(inst_enable), 32'd1);
        check({tag, "_inst"}, inst, data);
        check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        tick();
        check({tag, "_single_pulse"}, 32'(inst_enable), 32'd0);
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
        pc_ce   = 1'b1;
        pc_addr = addr;
        exp_q.push_back(data);
        tick();
        pc_ce = 1'b0;
        check({tag, "_enable"}, 32'(inst_enable), 32'd1);
        check({tag, "_inst"}, inst, data);
        check({tag, "_no_req"}, 32'(mem_req), 32'd0);
        tick();
        check({tag, "_single_pulse"}, 32'(inst_enable), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        pc_ce     = 1'b0;
        pc_addr   = '0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        tick();
        tick();
        check("rst_enable", 32'(inst_enable), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b1;
        tick();

        // 1: cold miss, single-cycle ack+valid, then hit
        start_miss("t1_miss", 32'h0000_0010);
        fill_same_cycle("t1_fill", 32'h0050_0093);
        expect_hit("t1_hit", 32'h0000_0010, 32'h0050_0093);

        // 2: split handshake; a fetch during the wait is ignored
        start_miss("t2_miss", 32'h0000_0040);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("t2_req_after_ack", 32'(mem_req), 32'd0);
        pc_ce   = 1'b1;
        pc_addr = 32'h0000_0010;
        tick();
        check("t2_wait_no_enable_a", 32'(inst_enable), 32'd0);
        tick();
        check("t2_wait_no_enable_b", 32'(inst_enable), 32'd0);
        pc_ce     = 1'b0;
        mem_valid = 1'b1;
        mem_data  = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        tick();
        mem_valid = 1'b0;
        check("t2_enable", 32'(inst_enable), 32'd1);
        check("t2_inst", inst, 32'h1234_5678);
        tick();
        check("t2_single_pulse", 32'(inst_enable), 32'd0);
        check("t2_inst_hold", inst, 32'h1234_5678);

        // 3: conflict eviction at index 1; second fill holds req until a late ack
        start_miss("t3_a", 32'h0000_0004);
        fill_same_cycle("t3_a_fill", 32'hAAAA_0004);
        start_miss("t3_b", 32'h0000_0104);
        tick();
        check("t3_b_hold_req", 32'(mem_req), 32'd1);
        check("t3_b_hold_addr", mem_addr, 32'h0000_0104);
        mem_valid = 1'b1;
        mem_data  = 32'h5555_5555;
        tick();
        check("t3_valid_without_ack", 32'(inst_enable), 32'd0);
        check("t3_b_still_req", 32'(mem_req), 32'd1);
        check("t3_b_still_addr", mem_addr, 32'h0000_0104);
        fill_same_cycle("t3_b_fill", 32'hBBBB_0104);
        start_miss("t3_refetch", 32'h0000_0004);
        fill_same_cycle("t3_refill", 32'hAAAA_0004);

        // 4: flush in IDLE swallows the fetch; flush on the fill edge delivers but drops the line
        start_miss("t4_a", 32'h0000_0008);
        fill_same_cycle("t4_a_fill", 32'hCCCC_0008);
        expect_hit("t4_hit", 32'h0000_0008, 32'hCCCC_0008);
        flush   = 1'b1;
        pc_ce   = 1'b1;
        pc_addr = 32'h0000_0008;
        tick();
        flush = 1'b0;
        pc_ce = 1'b0;
        check("t4_flush_no_enable", 32'(inst_enable), 32'd0);
        check("t4_flush_no_req", 32'(mem_req), 32'd0);
        start_miss("t4_after_flush", 32'h0000_0008);
        flush = 1'b1;
        fill_same_cycle("t4_flush_fill", 32'hCCCC_0008);
        flush = 1'b0;
        start_miss("t4_refetch", 32'h0000_0008);
        fill_same_cycle("t4_refill", 32'hCCCC_0008);

        // 5: reset while waiting for data; a late mem_valid is ignored
        start_miss("t5_miss", 32'h0000_0020);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        rst = 1'b0;
        #1;
        check("t5_rst_mem_req", 32'(mem_req), 32'd0);
        check("t5_rst_enable", 32'(inst_enable), 32'd0);
        check("t5_rst_inst", inst, 32'd0);
        check("t5_rst_mem_addr", mem_addr, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        mem_valid = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
        tick();
        mem_valid = 1'b0;
        check("t5_late_valid", 32'(inst_enable), 32'd0);
        start_miss("t5_refetch", 32'h0000_0020);
        fill_same_cycle("t5_refill", 32'h2020_2020);
        start_miss("t5_cleared_line", 32'h0000_0008);
        fill_same_cycle("t5_refill_8", 32'hCCCC_0008);

        // 6: back-to-back hits, one response per cycle
        start_miss("t6_a", 32'h0000_0000);
        fill_same_cycle("t6_a_fill", 32'h0000_0A00);
        start_miss("t6_b", 32'h0000_0004);
        fill_same_cycle("t6_b_fill", 32'h0000_0B04);
        pc_ce   = 1'b1;
        pc_addr = 32'h0000_0000;
        exp_q.push_back(32'h0000_0A00);
        tick();
        check("t6_hit0_enable", 32'(inst_enable), 32'd1);
        check("t6_hit0_inst", inst, 32'h0000_0A00);
        pc_addr = 32'h0000_0004;
        exp_q.push_back(32'h0000_0B04);
        tick();
        check("t6_hit1_enable", 32'(inst_enable), 32'd1);
        check("t6_hit1_inst", inst, 32'h0000_0B04);
        pc_addr = 32'h0000_0008;
        exp_q.push_back(32'hCCCC_0008);
        tick();
        check("t6_hit2_enable", 32'(inst_enable), 32'd1);
        check("t6_hit2_inst", inst, 32'hCCCC_0008);
        check("t6_no_req", 32'(mem_req), 32'd0);
        pc_ce = 1'b0;
        tick();
        check("t6_idle", 32'(inst_enable), 32'd0);
        tick();

        check("sb_pending", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
